// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and the MEM stage.
// Optional fetch anti-starvation guard is enabled by defining FETCH_STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ack_o,
    output logic                  stall_if_o,
    output logic                  stall_mem_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("unified_mem_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
    end

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             owner_data;
    logic             we_lat;
    logic             grant_data;
    logic             capture;

`ifdef FETCH_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (if_req_i || d_req_i) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (capture) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture     = (state == WAIT) && (wait_cnt == '0);
        stall_if_o  = if_req_i & ~if_ack_o;
        stall_mem_o = d_req_i & ~d_ack_o;
`ifdef FETCH_STARVE_GUARD_EN
        grant_data  = d_req_i && !(if_req_i && (starve_cnt >= STARVE_W'(STARVE_LIMIT)));
`else
        grant_data  = d_req_i;
`endif
    end

    // The command is latched at grant so later input changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            owner_data  <= 1'b0;
            we_lat      <= 1'b0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
        end else begin
            mem_en_o <= 1'b0;
            mem_we_o <= 1'b0;
            if_ack_o <= 1'b0;
            d_ack_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req_i || d_req_i) begin
                        owner_data  <= grant_data;
                        we_lat      <= grant_data & d_we_i;
                        mem_en_o    <= 1'b1;
                        mem_we_o    <= grant_data & d_we_i;
                        mem_addr_o  <= grant_data ? d_addr_i : if_addr_i;
                        mem_wdata_o <= grant_data ? d_wdata_i : '0;
                        wait_cnt    <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        if (owner_data) begin
                            if (!we_lat) d_rdata_o <= mem_rdata_i;
                            d_ack_o <= 1'b1;
                        end else begin
                            if_rdata_o <= mem_rdata_i;
                            if_ack_o   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STARVE_GUARD_EN
    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE && (if_req_i || d_req_i)) begin
            if (!grant_data)
                starve_cnt <= '0;
            else if (if_req_i && starve_cnt < STARVE_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

endmodule
